// File: rtl/ctrl_word_pipe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ctrl_word_pipe_stage
// Description : Pipeline register directly upstream of the bus-control
//               decoders. Holds the decoded 26-bit control word and drives
//               its encoded select fields into the decoders. A two-entry
//               elastic buffer (output register + skid register) absorbs
//               memory wait states. In_Ready is derived from registers only,
//               so no combinational path runs from Mem_Wait to In_Ready.
//               A NOP word is injected on bubbles and flushes. While memory
//               is stalled, fields with side effects are forced to their
//               idle codes so that a held word cannot load, increment or
//               decrement twice.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        width of the saturating stall-cycle counter
// Ports
//   Clock_In     in   1      sole clock, rising edge
//   Reset_In     in   1      synchronous active-high reset
//   In_Valid     in   1      upstream control word valid
//   In_Ready     out  1      stage accepts In_Word this cycle
//   In_Word      in   26     [25:22]BusAssert [21:18]BusLoad [17:15]XferAssert
//                            [14:11]XferLoadDec [10:9]IncPCRA [8:7]IncSPSIDI
//                            [6:5]LHS [4:3]RHS [2:0]AddrSel
//   Flush        in   1      discard everything held (redirect)
//   Mem_Wait     in   1      memory not ready, stage holds
//   Stall_Clr    in   1      clear Stall_Count
//   Out_Valid    out  1      output register holds a real instruction step
//   Bus_Assert .. AddrSel    select fields, output register with stall mask
//   Stall_Count  out  CNT_W  Mem_Wait cycles seen, saturating
// ============================================================================
module ctrl_word_pipe_stage #(
    parameter int CNT_W = 8
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [25:0]      In_Word,
    input  logic             Flush,
    input  logic             Mem_Wait,
    input  logic             Stall_Clr,
    output logic             Out_Valid,
    output logic [3:0]       Bus_Assert,
    output logic [3:0]       Bus_Load,
    output logic [2:0]       Xfer_Assert,
    output logic [3:0]       XferLoadDec,
    output logic [1:0]       Inc_PCRA,
    output logic [1:0]       Inc_SPSIDI,
    output logic [1:0]       LHS,
    output logic [1:0]       RHS,
    output logic [2:0]       AddrSel,
    output logic [CNT_W-1:0] Stall_Count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Every decoder parks on its unused code: IncPCRA=3, AddrSel=7, rest 0.
    localparam logic [25:0]      c_NOP_WORD     = 26'h0000607;
    localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    // Idle codes forced onto the side-effect fields while memory stalls.
    localparam logic [3:0]       c_BUS_LOAD_IDLE = 4'd0;
    localparam logic [3:0]       c_XLD_IDLE      = 4'd0;
    localparam logic [1:0]       c_INC_PCRA_IDLE = 2'd3;
    localparam logic [1:0]       c_INC_SP_IDLE   = 2'd0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [25:0]      r_out_word;
    logic             r_out_valid;
    logic [25:0]      r_skid_word;
    logic             r_skid_valid;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Handshake and control terms
    // ------------------------------------------------------------------
    logic w_in_ready;
    logic w_advance;
    logic w_flush_req;
    logic w_flush_now;
    logic w_accept;

    // Ready depends on registered state only; an occupied skid or a flush
    // waiting for the stall to end both close the input.
    assign w_in_ready  = ~r_skid_valid & ~r_flush_pend;
    assign w_advance   = ~Mem_Wait;

    // A pending flush and a fresh flush request are the same action.
    assign w_flush_req = Flush | r_flush_pend;
    assign w_flush_now = w_flush_req & w_advance;

    // A word offered alongside Flush is discarded: it would be younger
    // than the redirect and therefore belongs to the wrong path.
    assign w_accept    = In_Valid & w_in_ready & ~Flush;

    assign In_Ready    = w_in_ready;

    // ------------------------------------------------------------------
    // Elastic buffer: output register + skid register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_out_word   <= c_NOP_WORD;
            r_out_valid  <= 1'b0;
            r_skid_word  <= c_NOP_WORD;
            r_skid_valid <= 1'b0;
            r_flush_pend <= 1'b0;
        end else if (w_flush_now) begin
            // Memory is free: drop everything held and park on NOP.
            r_out_word   <= c_NOP_WORD;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_flush_pend <= 1'b0;
        end else if (w_flush_req) begin
            // Flush arrived while stalled: remember it, hold both entries
            // so the stalled bus cycle still sees a stable word.
            r_flush_pend <= 1'b1;
        end else if (w_advance) begin
            if (r_skid_valid) begin
                // Older word in the skid drains first; input is closed.
                r_out_word   <= r_skid_word;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_word   <= In_Word;
                r_out_valid  <= 1'b1;
            end else begin
                // Bubble: inject NOP so decoders never repeat a step.
                r_out_word   <= c_NOP_WORD;
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            // Stalled: the output register holds, the arriving word is
            // parked in the skid register.
            r_skid_word  <= In_Word;
            r_skid_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_stall_cnt <= '0;
        end else if (Stall_Clr) begin
            r_stall_cnt <= '0;
        end else if (Mem_Wait && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign Stall_Count = r_stall_cnt;

    // ------------------------------------------------------------------
    // Field split of the output register
    // ------------------------------------------------------------------
    logic [3:0] w_bus_assert;
    logic [3:0] w_bus_load;
    logic [2:0] w_xfer_assert;
    logic [3:0] w_xfer_load_dec;
    logic [1:0] w_inc_pcra;
    logic [1:0] w_inc_spsidi;
    logic [1:0] w_lhs;
    logic [1:0] w_rhs;
    logic [2:0] w_addr_sel;

    assign w_bus_assert    = r_out_word[25:22];
    assign w_bus_load      = r_out_word[21:18];
    assign w_xfer_assert   = r_out_word[17:15];
    assign w_xfer_load_dec = r_out_word[14:11];
    assign w_inc_pcra      = r_out_word[10:9];
    assign w_inc_spsidi    = r_out_word[8:7];
    assign w_lhs           = r_out_word[6:5];
    assign w_rhs           = r_out_word[4:3];
    assign w_addr_sel      = r_out_word[2:0];

    // ------------------------------------------------------------------
    // Stall mask
    // ------------------------------------------------------------------
    // The held word is presented on every stalled cycle. Loads and
    // pointer inc/dec would fire once per cycle, so they are parked on
    // their idle codes until memory releases. Drive-side fields (asserts,
    // ALU operand selects, address select) must stay stable for the
    // pending memory access and pass through unchanged.
    always_comb begin
        Bus_Assert  = w_bus_assert;
        Bus_Load    = w_bus_load;
        Xfer_Assert = w_xfer_assert;
        XferLoadDec = w_xfer_load_dec;
        Inc_PCRA    = w_inc_pcra;
        Inc_SPSIDI  = w_inc_spsidi;
        LHS         = w_lhs;
        RHS         = w_rhs;
        AddrSel     = w_addr_sel;
        if (Mem_Wait) begin
            Bus_Load    = c_BUS_LOAD_IDLE;
            XferLoadDec = c_XLD_IDLE;
            Inc_PCRA    = c_INC_PCRA_IDLE;
            Inc_SPSIDI  = c_INC_SP_IDLE;
        end
    end

    assign Out_Valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_word_pipe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_word_pipe_stage
// Description : Self-checking bench for ctrl_word_pipe_stage. Accepted words
//               are queued on the scoreboard and compared when the stage
//               presents them; directed checks cover reset, the stall mask,
//               flushes, stall counter saturation and reset mid-stall.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_word_pipe_stage;

    localparam int          CNT_W = 3;
    localparam logic [25:0] c_NOP = 26'h0000607;

    logic             clk = 1'b0;
    logic             Reset_In;
    logic             In_Valid;
    logic             In_Ready;
    logic [25:0]      In_Word;
    logic             Flush;
    logic             Mem_Wait;
    logic             Stall_Clr;
    logic             Out_Valid;
    logic [3:0]       Bus_Assert;
    logic [3:0]       Bus_Load;
    logic [2:0]       Xfer_Assert;
    logic [3:0]       XferLoadDec;
    logic [1:0]       Inc_PCRA;
    logic [1:0]       Inc_SPSIDI;
    logic [1:0]       LHS;
    logic [1:0]       RHS;
    logic [2:0]       AddrSel;
    logic [CNT_W-1:0] Stall_Count;

    ctrl_word_pipe_stage #(.CNT_W(CNT_W)) u_dut (
        .Clock_In    (clk),
        .Reset_In    (Reset_In),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .In_Word     (In_Word),
        .Flush       (Flush),
        .Mem_Wait    (Mem_Wait),
        .Stall_Clr   (Stall_Clr),
        .Out_Valid   (Out_Valid),
        .Bus_Assert  (Bus_Assert),
        .Bus_Load    (Bus_Load),
        .Xfer_Assert (Xfer_Assert),
        .XferLoadDec (XferLoadDec),
        .Inc_PCRA    (Inc_PCRA),
        .Inc_SPSIDI  (Inc_SPSIDI),
        .LHS         (LHS),
        .RHS         (RHS),
        .AddrSel     (AddrSel),
        .Stall_Count (Stall_Count)
    );

    always #5 clk = ~clk;

    logic [25:0] w_obs_word;
    assign w_obs_word = {Bus_Assert, Bus_Load, Xfer_Assert, XferLoadDec,
                         Inc_PCRA, Inc_SPSIDI, LHS, RHS, AddrSel};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [25:0] sb_q[$];
    logic [25:0] tx_q[$];
    logic        pend_m = 1'b0;
    logic        drv_done;
    logic [25:0] w1, w2, w3, w4, w5, w6, w7, w8, w10, w11;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [25:0] mask_word(input logic [25:0] w);
        return {w[25:22], 4'b0000, w[17:15], 4'b0000, 2'b11, 2'b00, w[6:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Offer every word in tx_q in order, holding each until accepted.
    task automatic drive_all();
        while (tx_q.size() != 0) begin
            int guard = 0;
            In_Valid = 1'b1;
            In_Word  = tx_q[0];
            @(negedge clk);
            while (!In_Ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("drive_timeout", 32'(In_Ready), 32'd1);
            void'(tx_q.pop_front());
            @(posedge clk);
            #1;
        end
        In_Valid = 1'b0;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [25:0] exp_w;
        if (Reset_In) begin
            sb_q.delete();
            pend_m = 1'b0;
        end else begin
            if (Out_Valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'(Out_Valid), 32'd0);
                end else if (Mem_Wait) begin
                    chk("sb_stalled_word", 32'(w_obs_word), 32'(mask_word(sb_q[0])));
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("sb_word", 32'(w_obs_word), 32'(exp_w));
                end
            end else begin
                chk("sb_idle_nop", 32'(w_obs_word), 32'(c_NOP));
            end
            if (In_Valid && In_Ready) sb_q.push_back(In_Word);
            if ((Flush || pend_m) && !Mem_Wait) begin
                sb_q.delete();
                pend_m = 1'b0;
            end else if (Flush) begin
                pend_m = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        w1 = 26'h2F0F0F5; w2 = 26'h15A5A5A; w3 = 26'h3C3C3C3; w4 = 26'h0123456;
        w5 = 26'h1111111; w6 = 26'h2222222; w7 = 26'h3333333; w8 = 26'h0444444;
        w10 = 26'h1ABCDEF; w11 = 26'h2FEDCBA;
        Reset_In = 1'b1; In_Valid = 1'b0; In_Word = c_NOP;
        Flush = 1'b0; Mem_Wait = 1'b0; Stall_Clr = 1'b0; drv_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset_In = 1'b0;
        mid();
        chk("rst_out_valid",   32'(Out_Valid),   32'd0);
        chk("rst_in_ready",    32'(In_Ready),    32'd1);
        chk("rst_stall_count", 32'(Stall_Count), 32'd0);
        chk("rst_fields",      32'(w_obs_word),  32'(c_NOP));

        // Single word, one-cycle latency, then NOP bubble.
        tick(); In_Valid = 1'b1; In_Word = 26'h1234567;
        tick(); In_Valid = 1'b0;
        mid();
        chk("single_out_valid", 32'(Out_Valid),  32'd1);
        chk("single_fields",    32'(w_obs_word), 32'h1234567);
        tick(); mid();
        chk("bubble_out_valid", 32'(Out_Valid),  32'd0);
        chk("bubble_fields",    32'(w_obs_word), 32'(c_NOP));

        // Back-to-back with a 3-cycle stall after W1 lands.
        tick();
        tx_q = '{w1, w2, w3, w4};
        fork
            drive_all();
            begin
                int g = 0;
                @(posedge clk); #1;
                while (!Out_Valid && g < 20) begin @(posedge clk); #1; g++; end
                Mem_Wait = 1'b1;
                mid();
                chk("stall_bus_load",    32'(Bus_Load),    32'd0);
                chk("stall_xferloaddec", 32'(XferLoadDec), 32'd0);
                chk("stall_inc_pcra",    32'(Inc_PCRA),    32'd3);
                chk("stall_inc_spsidi",  32'(Inc_SPSIDI),  32'd0);
                chk("stall_bus_assert",  32'(Bus_Assert),  32'(w1[25:22]));
                chk("stall_addrsel",     32'(AddrSel),     32'(w1[2:0]));
                tick(); mid();
                chk("skid_in_ready", 32'(In_Ready), 32'd0);
                tick(); tick();
                Mem_Wait = 1'b0;
            end
        join
        repeat (4) tick();
        chk("b2b_drained", 32'(sb_q.size()), 32'd0);

        // Flush with skid full, memory free.
        In_Valid = 1'b1; In_Word = w5;
        tick(); Mem_Wait = 1'b1; In_Word = w6;
        tick(); In_Valid = 1'b0; Mem_Wait = 1'b0; Flush = 1'b1;
        mid();
        chk("flush_skid_full", 32'(In_Ready), 32'd0);
        tick(); Flush = 1'b0;
        mid();
        chk("flush_out_valid", 32'(Out_Valid),  32'd0);
        chk("flush_in_ready",  32'(In_Ready),   32'd1);
        chk("flush_fields",    32'(w_obs_word), 32'(c_NOP));
        repeat (3) tick();
        chk("flush_no_skid_word", 32'(sb_q.size()), 32'd0);

        // Flush during a 2-cycle stall.
        In_Valid = 1'b1; In_Word = w7;
        tick(); Mem_Wait = 1'b1; In_Word = w8;
        tick(); In_Valid = 1'b0; Flush = 1'b1;
        mid(); chk("pflush_rdy_a", 32'(In_Ready), 32'd0);
        tick(); Flush = 1'b0;
        mid(); chk("pflush_rdy_b", 32'(In_Ready), 32'd0);
        chk("pflush_hold_masked", 32'(w_obs_word), 32'(mask_word(w7)));
        tick(); Mem_Wait = 1'b0;
        mid(); chk("pflush_rdy_c", 32'(In_Ready), 32'd0);
        chk("pflush_hold_word", 32'(w_obs_word), 32'(w7));
        tick(); mid();
        chk("pflush_out_valid", 32'(Out_Valid),  32'd0);
        chk("pflush_in_ready",  32'(In_Ready),   32'd1);
        chk("pflush_fields",    32'(w_obs_word), 32'(c_NOP));

        // Stall counter saturation and clear.
        tick(); Stall_Clr = 1'b1;
        tick(); Stall_Clr = 1'b0; Mem_Wait = 1'b1;
        repeat (5) tick();
        mid(); chk("stall_cnt_5", 32'(Stall_Count), 32'd5);
        repeat (5) tick();
        mid(); chk("stall_cnt_sat", 32'(Stall_Count), 32'd7);
        tick(); Stall_Clr = 1'b1;
        tick(); Stall_Clr = 1'b0;
        mid(); chk("stall_cnt_clr", 32'(Stall_Count), 32'd0);
        tick();
        mid(); chk("stall_cnt_after_clr", 32'(Stall_Count), 32'd1);
        tick(); Mem_Wait = 1'b0;
        tick();

        // Reset mid-stall with skid full and flush pending.
        In_Valid = 1'b1; In_Word = w10;
        tick(); Mem_Wait = 1'b1; In_Word = w11;
        tick(); In_Valid = 1'b0; Flush = 1'b1;
        tick(); Flush = 1'b0; Reset_In = 1'b1;
        mid(); chk("prerst_in_ready", 32'(In_Ready), 32'd0);
        tick(); Reset_In = 1'b0; Mem_Wait = 1'b0;
        mid();
        chk("midrst_out_valid",   32'(Out_Valid),   32'd0);
        chk("midrst_in_ready",    32'(In_Ready),    32'd1);
        chk("midrst_stall_count", 32'(Stall_Count), 32'd0);
        chk("midrst_fields",      32'(w_obs_word),  32'(c_NOP));
        tick(); mid();
        chk("midrst_no_stale", 32'(Out_Valid), 32'd0);

        // Random words under random stalls.
        tick();
        for (int i = 0; i < 16; i++) tx_q.push_back(26'($urandom));
        fork
            begin
                drive_all();
                drv_done = 1'b1;
            end
            begin
                int n = 0;
                while (!drv_done && n < 400) begin
                    Mem_Wait = ($urandom_range(0, 9) < 3);
                    tick();
                    n++;
                end
                Mem_Wait = 1'b0;
            end
        join
        repeat (6) tick();
        chk("rand_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
